// File: rtl/dispatch_scheduler_pkg.sv
// Shared types and widths for the relief-queue dispatch scheduler.
package dispatch_pkg;

    localparam int unsigned PRIO_W = 2;
    localparam int unsigned ZONE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        SERVE,
        SETTLE
    } dispatch_state_t;

endpackage

// File: rtl/dispatch_scheduler_if.sv
// Offer handshake between the scheduler (master) and the field dispatch unit (slave).
interface dispatch_scheduler_if
    import dispatch_pkg::*;
#(
    parameter int unsigned NUM_TEAMS = 4
);
    localparam int unsigned TW = $clog2(NUM_TEAMS);

    logic              dispatch_valid;
    logic              dispatch_ready;
    logic [TW-1:0]     dispatch_team;
    logic [ZONE_W-1:0] dispatch_zone;
    logic [PRIO_W-1:0] dispatch_priority;
    logic              dispatch_evac;

    modport master (
        output dispatch_valid, dispatch_team, dispatch_zone, dispatch_priority, dispatch_evac,
        input  dispatch_ready
    );

    modport slave (
        input  dispatch_valid, dispatch_team, dispatch_zone, dispatch_priority, dispatch_evac,
        output dispatch_ready
    );

endinterface

// File: rtl/dispatch_scheduler_team_timer.sv
// Busy flag and mission countdown for one rescue team; busy_nxt exposes the
// next-state flag so the parent can register an aligned busy count.
module team_timer #(
    parameter int unsigned TIMER_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_ticks,
    input  logic               early_release,
    output logic               busy,
    output logic               busy_nxt
);

    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_nxt;

    // Release and expiry share one clear path, so coincident events clear once.
    always_comb begin
        busy_nxt  = busy;
        timer_nxt = timer;
        if (load) begin
            busy_nxt  = 1'b1;
            timer_nxt = load_ticks;
        end else if (busy) begin
            if (early_release || timer == TIMER_W'(1)) begin
                busy_nxt  = 1'b0;
                timer_nxt = '0;
            end else begin
                timer_nxt = timer - TIMER_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            timer <= '0;
        end else begin
            busy  <= busy_nxt;
            timer <= timer_nxt;
        end
    end

endmodule

// File: rtl/dispatch_scheduler.sv
// Holds the merged queue head until a team is free, offers it, pulses serve once per dispatch.
// Optional macro DISPATCH_EVAC_RESERVE_EN reserves team 0 for evacuation requests.
module dispatch_scheduler
    import dispatch_pkg::*;
#(
    parameter int unsigned NUM_TEAMS  = 4,
    parameter int unsigned TIMER_W    = 8,
    parameter int unsigned BASE_TICKS = 16,
    parameter int unsigned STEP_TICKS = 8,
    parameter int unsigned EVAC_TICKS = 40
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            head_valid,
    input  logic [ZONE_W-1:0]               head_zone,
    input  logic [PRIO_W-1:0]               head_priority,
    input  logic                            head_evac,
    input  logic                            hold,
    input  logic [NUM_TEAMS-1:0]            team_release,
    output logic                            serve,
    output logic [NUM_TEAMS-1:0]            teams_busy,
    output logic [$clog2(NUM_TEAMS):0]      busy_count,
    dispatch_scheduler_if.master            disp
);

    localparam int unsigned TW = $clog2(NUM_TEAMS);
    localparam int unsigned CW = TW + 1;

    if (NUM_TEAMS < 2 || NUM_TEAMS > 8) begin : g_bad_teams
        $error("dispatch_scheduler: NUM_TEAMS must be in 2..8");
    end
    if (BASE_TICKS == 0 || EVAC_TICKS == 0) begin : g_bad_zero
        $error("dispatch_scheduler: mission lengths must be non-zero");
    end
    if ((BASE_TICKS + 3 * STEP_TICKS) >= (1 << TIMER_W) || EVAC_TICKS >= (1 << TIMER_W)) begin : g_bad_width
        $error("dispatch_scheduler: mission length does not fit TIMER_W");
    end

    dispatch_state_t     state;
    logic [NUM_TEAMS-1:0] eligible;
    logic [NUM_TEAMS-1:0] free_mask;
    logic [NUM_TEAMS-1:0] busy_nxt;
    logic [NUM_TEAMS-1:0] load;
    logic [TW-1:0]        pick;
    logic                 found;
    logic                 accept;
    logic [TIMER_W-1:0]   mission_ticks;
    logic [CW-1:0]        count_nxt;

    always_comb begin
        eligible = '1;
`ifdef DISPATCH_EVAC_RESERVE_EN
        eligible[0] = head_evac;
`endif
        free_mask = ~teams_busy & eligible;
        found     = 1'b0;
        pick      = '0;
        for (int unsigned i = 0; i < NUM_TEAMS; i++) begin
            if (free_mask[i] && !found) begin
                found = 1'b1;
                pick  = TW'(i);
            end
        end
    end

    assign accept = (state == OFFER) && disp.dispatch_valid && disp.dispatch_ready;

    always_comb begin
        if (disp.dispatch_evac) begin
            mission_ticks = TIMER_W'(EVAC_TICKS);
        end else begin
            mission_ticks = TIMER_W'(BASE_TICKS)
                          + TIMER_W'(disp.dispatch_priority) * TIMER_W'(STEP_TICKS);
        end
    end

    for (genvar g = 0; g < NUM_TEAMS; g++) begin : g_team
        assign load[g] = accept && (disp.dispatch_team == TW'(g));

        team_timer #(
            .TIMER_W (TIMER_W)
        ) u_team_timer (
            .clk           (clk),
            .rst_n         (rst_n),
            .load          (load[g]),
            .load_ticks    (mission_ticks),
            .early_release (team_release[g]),
            .busy          (teams_busy[g]),
            .busy_nxt      (busy_nxt[g])
        );
    end

    // Count is built from next-state flags so it updates on the same edge as teams_busy.
    always_comb begin
        count_nxt = '0;
        for (int unsigned i = 0; i < NUM_TEAMS; i++) begin
            count_nxt = count_nxt + CW'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_count <= '0;
        end else begin
            busy_count <= count_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= IDLE;
            serve                  <= 1'b0;
            disp.dispatch_valid    <= 1'b0;
            disp.dispatch_team     <= '0;
            disp.dispatch_zone     <= '0;
            disp.dispatch_priority <= '0;
            disp.dispatch_evac     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    serve <= 1'b0;
                    if (head_valid && !hold && found) begin
                        disp.dispatch_valid    <= 1'b1;
                        disp.dispatch_team     <= pick;
                        disp.dispatch_zone     <= head_zone;
                        disp.dispatch_priority <= head_priority;
                        disp.dispatch_evac     <= head_evac;
                        state                  <= OFFER;
                    end
                end
                OFFER: begin
                    if (disp.dispatch_ready) begin
                        disp.dispatch_valid <= 1'b0;
                        serve               <= 1'b1;
                        state               <= SERVE;
                    end
                end
                SERVE: begin
                    serve <= 1'b0;
                    state <= SETTLE;
                end
                SETTLE: begin
                    state <= IDLE;
                end
                default: begin
                    serve               <= 1'b0;
                    disp.dispatch_valid <= 1'b0;
                    state               <= IDLE;
                end
            endcase
        end
    end

endmodule
